// File: rtl/rob_commit.sv
// rtl/rob_commit.sv - in-order ROB retirement: consume handshake, registered RF writeback,
// serialised store commit and retirement counters.
module rob_commit #(
  parameter int EXT_COUNT    = 4,
  parameter int EXTCOUNTLOG2 = $clog2(EXT_COUNT)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [EXT_COUNT-1:0]             slot_valid,
  input  logic [EXT_COUNT-1:0]             slot_kill,
  input  logic [EXT_COUNT-1:0][4:0]        slot_dest_reg,
  input  logic [EXT_COUNT-1:0]             slot_dest_reg_valid,
  input  logic [EXT_COUNT-1:0][31:0]       slot_result,
  input  logic [EXT_COUNT-1:0]             slot_is_store,
  output logic                             consume,
  output logic [EXTCOUNTLOG2-1:0]          consume_count,
  output logic [EXT_COUNT-1:0]             rf_we,
  output logic [EXT_COUNT-1:0][4:0]        rf_waddr,
  output logic [EXT_COUNT-1:0][31:0]       rf_wdata,
  output logic                             st_commit_req,
  input  logic                             st_commit_ack,
  output logic [31:0]                      retired_count,
  output logic [31:0]                      killed_count
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  localparam logic [EXTCOUNTLOG2:0] ONE = 1;

  logic [0:0]                state, state_nxt;
  logic [EXT_COUNT-1:0]      retire, wr_cand, we_nxt;
  logic [EXTCOUNTLOG2:0]     n, live_n, kill_n;
  logic                      stop;

  // Retire mask is always a contiguous prefix starting at slot 0.
  always_comb begin
    retire    = '0;
    stop      = 1'b0;
    state_nxt = state;
    if (state == IDLE) begin
      for (int i = 0; i < EXT_COUNT; i++) begin
        if (!slot_valid[i] || (slot_is_store[i] && !slot_kill[i]))
          stop = 1'b1;
        if (!stop)
          retire[i] = 1'b1;
      end
      if (slot_valid[0] && slot_is_store[0] && !slot_kill[0])
        state_nxt = WAIT;
    end else if (st_commit_ack) begin
      retire[0] = 1'b1;
      state_nxt = IDLE;
    end
  end

  always_comb begin
    n      = '0;
    live_n = '0;
    kill_n = '0;
    for (int i = 0; i < EXT_COUNT; i++) begin
      if (retire[i]) begin
        n = n + ONE;
        if (slot_kill[i])
          kill_n = kill_n + ONE;
        else
          live_n = live_n + ONE;
      end
    end
  end

  assign consume       = |retire;
  assign consume_count = consume ? EXTCOUNTLOG2'(n - ONE) : '0;

  // Youngest writer of a register within the retiring group wins.
  always_comb begin
    for (int i = 0; i < EXT_COUNT; i++)
      wr_cand[i] = retire[i] && !slot_kill[i] && slot_dest_reg_valid[i] &&
                   (slot_dest_reg[i] != 5'd0);
    we_nxt = wr_cand;
    for (int i = 0; i < EXT_COUNT; i++)
      for (int j = 0; j < EXT_COUNT; j++)
        if (j > i && wr_cand[j] && slot_dest_reg[j] == slot_dest_reg[i])
          we_nxt[i] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      st_commit_req <= 1'b0;
      rf_we         <= '0;
      rf_waddr      <= '0;
      rf_wdata      <= '0;
      retired_count <= '0;
      killed_count  <= '0;
    end else begin
      state         <= state_nxt;
      st_commit_req <= (state_nxt == WAIT);
      rf_we         <= we_nxt;
      rf_waddr      <= slot_dest_reg;
      rf_wdata      <= slot_result;
      if (consume) begin
        retired_count <= retired_count + 32'(live_n);
        killed_count  <= killed_count + 32'(kill_n);
      end
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// tb/tb_rob_commit.sv - self-checking bench for rob_commit: vector table, directed
// store/reset sequences and randomized traffic against a reference model.
module tb_rob_commit;

  logic              clock = 1'b0;
  logic              reset;
  logic [3:0]        slot_valid, slot_kill, slot_dest_reg_valid, slot_is_store;
  logic [3:0][4:0]   slot_dest_reg;
  logic [3:0][31:0]  slot_result;
  logic              consume;
  logic [1:0]        consume_count;
  logic [3:0]        rf_we;
  logic [3:0][4:0]   rf_waddr;
  logic [3:0][31:0]  rf_wdata;
  logic              st_commit_req, st_commit_ack;
  logic [31:0]       retired_count, killed_count;

  rob_commit dut (
    .clock(clock), .reset(reset),
    .slot_valid(slot_valid), .slot_kill(slot_kill),
    .slot_dest_reg(slot_dest_reg), .slot_dest_reg_valid(slot_dest_reg_valid),
    .slot_result(slot_result), .slot_is_store(slot_is_store),
    .consume(consume), .consume_count(consume_count),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .st_commit_req(st_commit_req), .st_commit_ack(st_commit_ack),
    .retired_count(retired_count), .killed_count(killed_count)
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_fail = 0;
  bit m_wait = 0;
  int m_ret = 0, m_kill = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]       valid, kill, store, dv;
    logic [3:0][4:0]  dest;
    logic [3:0][31:0] result;
    logic             exp_consume;
    logic [1:0]       exp_cc;
    logic [3:0]       exp_we;
    int               dret, dkill;
  } vec_t;

  vec_t tbl[7];

  task automatic set_slots(input vec_t v);
    slot_valid = v.valid; slot_kill = v.kill; slot_is_store = v.store;
    slot_dest_reg_valid = v.dv; slot_dest_reg = v.dest; slot_result = v.result;
  endtask

  // One clock of stimulus judged by the reference model: retire the longest in-order
  // run of completed non-store entries, stores only alone after an ack, last writer wins.
  task automatic cycle(input logic ack);
    int n, dr, dk;
    bit nw;
    int last[32];
    logic [3:0] ewe;
    logic [3:0][4:0] sd;
    logic [3:0][31:0] sr;
    st_commit_ack = ack;
    #1;
    if (!m_wait) begin
      n = 0;
      while (n < 4 && slot_valid[n] && !(slot_is_store[n] && !slot_kill[n])) n++;
      nw = (n == 0) && slot_valid[0] && slot_is_store[0] && !slot_kill[0];
    end else begin
      n = ack ? 1 : 0;
      nw = !ack;
    end
    for (int r = 0; r < 32; r++) last[r] = -1;
    dr = 0; dk = 0;
    for (int i = 0; i < n; i++) begin
      if (slot_kill[i]) dk++;
      else begin
        dr++;
        if (slot_dest_reg_valid[i] && slot_dest_reg[i] != 0) last[slot_dest_reg[i]] = i;
      end
    end
    for (int i = 0; i < 4; i++)
      ewe[i] = (i < n) && !slot_kill[i] && slot_dest_reg_valid[i] &&
               slot_dest_reg[i] != 0 && last[slot_dest_reg[i]] == i;
    chk("consume", 32'(consume), 32'(n > 0));
    chk("consume_count", 32'(consume_count), (n > 0) ? n - 1 : 0);
    sd = slot_dest_reg; sr = slot_result;
    @(posedge clock); #1;
    m_wait = nw; m_ret += dr; m_kill += dk;
    chk("rf_we", 32'(rf_we), 32'(ewe));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rf_waddr%0d", i), 32'(rf_waddr[i]), 32'(sd[i]));
      chk($sformatf("rf_wdata%0d", i), rf_wdata[i], sr[i]);
    end
    chk("st_commit_req", 32'(st_commit_req), 32'(m_wait));
    chk("retired_count", retired_count, 32'(m_ret));
    chk("killed_count", killed_count, 32'(m_kill));
  endtask

  initial begin
    tbl[0] = '{4'b1111, 4'b0000, 4'b0000, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1},
               {32'h44, 32'h33, 32'h22, 32'h11}, 1'b1, 2'd3, 4'b1111, 4, 0};
    tbl[1] = '{4'b1011, 4'b0000, 4'b0000, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1},
               {32'h4, 32'h3, 32'h2, 32'h1}, 1'b1, 2'd1, 4'b0011, 2, 0};
    tbl[2] = '{4'b0111, 4'b0110, 4'b0100, 4'b0011, {5'd0, 5'd9, 5'd5, 5'd6},
               {32'h0, 32'h3, 32'h2, 32'h1}, 1'b1, 2'd2, 4'b0001, 1, 2};
    tbl[3] = '{4'b0111, 4'b0000, 4'b0000, 4'b0111, {5'd0, 5'd7, 5'd0, 5'd7},
               {32'h0, 32'hB, 32'h5, 32'hA}, 1'b1, 2'd2, 4'b0100, 3, 0};
    tbl[4] = '{4'b0000, 4'b0000, 4'b0000, 4'b1111, {5'd1, 5'd2, 5'd3, 5'd4},
               {32'h1, 32'h2, 32'h3, 32'h4}, 1'b0, 2'd0, 4'b0000, 0, 0};
    tbl[5] = '{4'b1101, 4'b0001, 4'b0001, 4'b1111, {5'd1, 5'd2, 5'd3, 5'd4},
               {32'h1, 32'h2, 32'h3, 32'h4}, 1'b1, 2'd0, 4'b0000, 0, 1};
    tbl[6] = '{4'b1111, 4'b0000, 4'b0010, 4'b1111, {5'd3, 5'd2, 5'd1, 5'd8},
               {32'h4, 32'h3, 32'h2, 32'h1}, 1'b1, 2'd0, 4'b0001, 1, 0};

    reset = 1'b1; st_commit_ack = 1'b0;
    slot_valid = '0; slot_kill = '0; slot_is_store = '0; slot_dest_reg_valid = '0;
    slot_dest_reg = '0; slot_result = '0;
    #12;
    chk("reset consume", 32'(consume), 32'd0);
    chk("reset consume_count", 32'(consume_count), 32'd0);
    chk("reset st_commit_req", 32'(st_commit_req), 32'd0);
    chk("reset rf_we", 32'(rf_we), 32'd0);
    chk("reset rf_waddr", 32'(rf_waddr), 32'd0);
    chk("reset rf_wdata0", rf_wdata[0], 32'd0);
    chk("reset retired_count", retired_count, 32'd0);
    chk("reset killed_count", killed_count, 32'd0);
    #1 reset = 1'b0;
    @(posedge clock); #1;

    for (int k = 0; k < 7; k++) begin
      set_slots(tbl[k]);
      st_commit_ack = 1'b0;
      #1;
      chk($sformatf("v%0d consume", k), 32'(consume), 32'(tbl[k].exp_consume));
      chk($sformatf("v%0d consume_count", k), 32'(consume_count), 32'(tbl[k].exp_cc));
      @(posedge clock); #1;
      m_ret += tbl[k].dret; m_kill += tbl[k].dkill;
      chk($sformatf("v%0d rf_we", k), 32'(rf_we), 32'(tbl[k].exp_we));
      for (int i = 0; i < 4; i++)
        if (tbl[k].exp_we[i]) begin
          chk($sformatf("v%0d rf_waddr%0d", k, i), 32'(rf_waddr[i]), 32'(tbl[k].dest[i]));
          chk($sformatf("v%0d rf_wdata%0d", k, i), rf_wdata[i], tbl[k].result[i]);
        end
      chk($sformatf("v%0d st_commit_req", k), 32'(st_commit_req), 32'd0);
      chk($sformatf("v%0d retired_count", k), retired_count, 32'(m_ret));
      chk($sformatf("v%0d killed_count", k), killed_count, 32'(m_kill));
    end

    // Live store at the head: wait for ack, retire it alone, then the rest drains.
    slot_valid = 4'b1111; slot_kill = '0; slot_is_store = 4'b0001; slot_dest_reg_valid = 4'b1110;
    slot_dest_reg = {5'd12, 5'd11, 5'd10, 5'd0};
    slot_result = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    cycle(1'b0);
    chk("store req raised", 32'(st_commit_req), 32'd1);
    for (int w = 0; w < 3; w++) cycle(1'b0);
    cycle(1'b1);
    chk("store req dropped", 32'(st_commit_req), 32'd0);
    slot_valid = 4'b0111; slot_is_store = '0;
    slot_dest_reg = {5'd0, 5'd12, 5'd11, 5'd10};
    slot_result = {32'h0, 32'hC3, 32'hC2, 32'hC1};
    slot_dest_reg_valid = 4'b0111;
    cycle(1'b0);
    chk("post-store rf_we", 32'(rf_we), 32'h7);

    // Ack outside WAIT has no effect.
    slot_valid = '0;
    cycle(1'b1);

    // Reset while waiting for an ack.
    slot_valid = 4'b0001; slot_is_store = 4'b0001; slot_kill = '0;
    cycle(1'b0);
    #2 reset = 1'b1;
    #1;
    chk("async reset req", 32'(st_commit_req), 32'd0);
    chk("async reset retired", retired_count, 32'd0);
    chk("async reset killed", killed_count, 32'd0);
    #1 reset = 1'b0;
    m_wait = 0; m_ret = 0; m_kill = 0;
    cycle(1'b0);
    chk("req reissued", 32'(st_commit_req), 32'd1);
    cycle(1'b1);

    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < 4; i++) begin
        slot_valid[i]          = ($urandom_range(0, 4) != 0);
        slot_kill[i]           = ($urandom_range(0, 5) == 0);
        slot_is_store[i]       = ($urandom_range(0, 6) == 0);
        slot_dest_reg_valid[i] = ($urandom_range(0, 3) != 0);
        slot_dest_reg[i]       = 5'($urandom_range(0, 7));
        slot_result[i]         = $urandom;
      end
      cycle(1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- In-order retirement engine at the extract end of the reorder buffer.
- Each cycle it inspects up to EXT_COUNT head slots and drives the ROB consume handshake.
- Writes retired results to the architectural register file through registered write ports.
- Serialises committed stores through a request/acknowledge handshake with the store buffer, and keeps retirement counters.

Parameters:
EXT_COUNT, 4, head slots examined and retire width per cycle
EXTCOUNTLOG2, $clog2(EXT_COUNT), width of consume_count

Ports:
clock  input  1  sole clock; all state on posedge
reset  input  1  asynchronous, active-high reset
slot_valid  input  [EXT_COUNT]x1  head slot i holds a completed entry (slot 0 = oldest)
slot_kill  input  [EXT_COUNT]x1  head slot i is squashed; retire without side effects
slot_dest_reg  input  [EXT_COUNT]x5  destination register of slot i
slot_dest_reg_valid  input  [EXT_COUNT]x1  slot i writes a register
slot_result  input  [EXT_COUNT]x32  result_lo of slot i
slot_is_store  input  [EXT_COUNT]x1  slot i is a store needing memory commit
consume  output  1  ROB pops consume_count+1 entries at next edge
consume_count  output  EXTCOUNTLOG2  number retired minus one
rf_we  output  [EXT_COUNT]x1  register-file write enable, port i
rf_waddr  output  [EXT_COUNT]x5  write address, port i
rf_wdata  output  [EXT_COUNT]x32  write data, port i
st_commit_req  output  1  request store buffer to commit oldest pending store
st_commit_ack  input  1  store buffer accepted the commit
retired_count  output  32  non-killed instructions retired (wraps)
killed_count  output  32  killed entries drained (wraps)

Behaviour:
- Reset: state=IDLE.
  - consume=0, consume_count=0, st_commit_req=0.
  - rf_we all 0, rf_waddr/rf_wdata 0.
  - Both counters 0.
  - Reset in WAIT drops st_commit_req immediately (async) and returns to IDLE.
- Retire-eligible prefix in IDLE: largest n such that slots 0..n-1 are all slot_valid, and no slot in 0..n-1 is (slot_is_store && !slot_kill).
  - The prefix stops at the first invalid slot or the first live store.
  - Killed stores are retireable like any killed entry.
- consume and consume_count are combinational from current slot inputs and state.
  - consume=1 iff n>=1.
  - consume_count=n-1.
  - When n=0, consume_count=0.
- Live store at slot 0 in IDLE:
  - n=0 and consume=0.
  - Next state WAIT; st_commit_req registered high from that edge.
- WAIT:
  - st_commit_req held high, consume=0 while st_commit_ack=0.
  - In a cycle with st_commit_ack=1: consume=1, consume_count=0 (retire the store slot only), st_commit_req falls at the next edge, next state IDLE.
  - Ack outside WAIT is ignored.
- Store retirement rules:
  - A store never retires in the same cycle as other instructions.
  - At most one store commit is in flight.
- Register writeback, registered one cycle after the consume cycle. For port i:
  - rf_we[i] <= consume && i<=consume_count && !slot_kill[i] && slot_dest_reg_valid[i] && slot_dest_reg[i]!=0 && no j>i within the group writes the same register (youngest wins).
  - rf_waddr[i] <= slot_dest_reg[i], rf_wdata[i] <= slot_result[i], unconditionally each cycle.
  - Stores with dest_reg_valid=0 produce no write.
- Counters, updated on the consume edge:
  - retired_count += number of non-killed retired slots.
  - killed_count += number of killed retired slots.
  - Both are 32-bit modulo.
- A slot beyond the first invalid slot is never inspected, even if it is valid; retirement is strictly in order.
- All slots invalid: consume=0 and no counter change.

Test Plan:
1. Slots 0-3 valid, non-store, dest r1,r2,r3,r4, data 0x11..0x44 -> consume=1, consume_count=3; next cycle rf_we=1111 with addresses 1..4 and data 0x11..0x44; retired_count=4.
2. Slot 0,1 valid, slot 2 invalid, slot 3 valid -> consume_count=1; only ports 0,1 write; retired_count +2.
3. Slot 0 live store, slots 1-3 valid -> consume=0; st_commit_req=1 next cycle; ack held low 3 cycles, consume stays 0; ack=1 -> consume=1, consume_count=0, req low next cycle; the following cycle retires slots 1-3.
4. Slots 0-2 valid, slot 1 killed with dest r5, slot 2 a killed store -> consume_count=2; rf_we=100; retired_count +1, killed_count +2; no st_commit_req.
5. Slots 0 and 2 both write r7 (data 0xA, 0xB), slot 1 writes r0 -> rf_we=001 on port 2 only, r7=0xB; r0 never written.
6. Assert reset while in WAIT with req high -> req=0 immediately, counters 0; after release, a live store at slot 0 re-issues the request.
